// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: synchronizes the SPI slave byte strobe and chip enable,
// decodes the two-byte register protocol and runs the prescaled up/down counter.
module spi_cmd_ctrl #(
    parameter int unsigned PRESCALE = 12_000_000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce0,
    input  logic             rx_toggle,
    input  logic [CNT_W-1:0] rx_byte,
    output logic [CNT_W-1:0] tx_byte,
    output logic [3:0]       led,
    output logic [CNT_W-1:0] count,
    output logic             busy
);
    localparam int unsigned   PW        = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_STEP  = 2'd1;
    localparam logic [1:0] A_LED   = 2'd2;
    localparam logic [1:0] A_COUNT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_HOLD} state_e;

    state_e           state_q, state_d;
    logic             ce0_s1_q, ce0_s2_q;
    logic             tog_s1_q, tog_s2_q, tog_prev_q, byte_ev_q;
    logic             busy_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] ledreg_q, ledreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tx_q, tx_d;
    logic [3:0]       led_q;
    logic [CNT_W-1:0] rd_data_c;
    logic             tick_c, wr_en_c, clr_c;
    logic             unused_cmd_bits;

    assign unused_cmd_bits = ^rx_byte[5:2];

    // Two-flop synchronizers; the byte event is registered so it lands on the 3rd edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce0_s1_q   <= 1'b1;
            ce0_s2_q   <= 1'b1;
            tog_s1_q   <= 1'b0;
            tog_s2_q   <= 1'b0;
            tog_prev_q <= 1'b0;
            byte_ev_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ce0_s1_q   <= ce0;
            ce0_s2_q   <= ce0_s1_q;
            tog_s1_q   <= rx_toggle;
            tog_s2_q   <= tog_s1_q;
            tog_prev_q <= tog_s2_q;
            byte_ev_q  <= tog_s2_q ^ tog_prev_q;
            busy_q     <= ~ce0_s2_q;
        end
    end

    assign tick_c  = (presc_q == PRESC_MAX);
    assign presc_d = tick_c ? '0 : presc_q + PW'(1);

    always_comb begin
        rd_data_c = ctrl_q;
        case (rx_byte[1:0])
            A_STEP:  rd_data_c = step_q;
            A_LED:   rd_data_c = ledreg_q;
            A_COUNT: rd_data_c = cnt_q;
            default: rd_data_c = ctrl_q;
        endcase
    end

    // Protocol FSM: chip-enable release overrides any byte event seen in the same cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        wr_en_c = 1'b0;
        clr_c   = 1'b0;
        if (ce0_s2_q) begin
            state_d = S_IDLE;
            if (state_q == S_IDLE) begin
                tx_d = cnt_q;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_d    = cnt_q;
                    state_d = S_CMD;
                end
                S_CMD: begin
                    if (byte_ev_q) begin
                        state_d = S_HOLD;
                        case (rx_byte[7:6])
                            OP_WRITE: begin
                                addr_d  = rx_byte[1:0];
                                state_d = S_DATA;
                            end
                            OP_READ:  tx_d  = rd_data_c;
                            OP_CLEAR: clr_c = 1'b1;
                            default:  ;
                        endcase
                    end
                end
                S_DATA: begin
                    if (byte_ev_q) begin
                        wr_en_c = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file and counter; host writes and CLEAR take priority over a tick.
    always_comb begin
        ctrl_d   = ctrl_q;
        step_d   = step_q;
        ledreg_d = ledreg_q;
        cnt_d    = cnt_q;
        if (tick_c && ctrl_q[0]) begin
            cnt_d = ctrl_q[1] ? cnt_q - step_q : cnt_q + step_q;
        end
        if (clr_c) begin
            cnt_d = '0;
        end
        if (wr_en_c) begin
            case (addr_q)
                A_CTRL:  ctrl_d   = rx_byte;
                A_STEP:  step_d   = rx_byte;
                A_LED:   ledreg_d = rx_byte;
                default: cnt_d    = rx_byte;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 2'd0;
            presc_q  <= '0;
            ctrl_q   <= '0;
            step_q   <= CNT_W'(1);
            ledreg_q <= '0;
            cnt_q    <= '0;
            tx_q     <= '0;
            led_q    <= 4'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            step_q   <= step_d;
            ledreg_q <= ledreg_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            led_q    <= ledreg_q[3:0];
        end
    end

    assign tx_byte = tx_q;
    assign led     = led_q;
    assign count   = cnt_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: constant-vector register table, hand-timed counter corner
// cases and a randomized phase checked against a timed-event register model.
module tb_spi_cmd_ctrl;
    localparam int unsigned PRESCALE = 4;
    localparam logic [1:0]  K_WR = 2'd0, K_RD = 2'd1, K_CLR = 2'd2;

    typedef struct {
        int unsigned at;
        logic [1:0]  kind;
        logic [1:0]  addr;
        logic [7:0]  data;
    } act_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] rd_cmd;
        logic [7:0] exp_rd;
        logic [3:0] exp_led;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce0 = 1'b1;
    logic       rx_toggle = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte, count;
    logic [3:0] led;
    logic       busy;

    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned n_edge = 0;
    logic [7:0]  ctrl_m, step_m, ledreg_m, cnt_m, cnt_prev_m, exp_tx_m, nxt_m;
    logic [3:0]  led_m;
    act_t        aq[$];
    act_t        cur_m;
    vec_t        vt[7];

    spi_cmd_ctrl #(.PRESCALE(PRESCALE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ce0(ce0), .rx_toggle(rx_toggle), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .led(led), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] reg_val(input logic [1:0] a);
        case (a)
            2'd0:    return ctrl_m;
            2'd1:    return step_m;
            2'd2:    return ledreg_m;
            default: return cnt_m;
        endcase
    endfunction

    // Reference model: ticks every PRESCALE edges after reset, host actions at scheduled edges.
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            n_edge++;
            led_m      = ledreg_m[3:0];
            cnt_prev_m = cnt_m;
            nxt_m      = cnt_m;
            if ((n_edge % PRESCALE) == 0 && ctrl_m[0])
                nxt_m = ctrl_m[1] ? cnt_m - step_m : cnt_m + step_m;
            if (aq.size() > 0 && aq[0].at == n_edge) begin
                cur_m = aq.pop_front();
                case (cur_m.kind)
                    K_WR: case (cur_m.addr)
                        2'd0:    ctrl_m   = cur_m.data;
                        2'd1:    step_m   = cur_m.data;
                        2'd2:    ledreg_m = cur_m.data;
                        default: nxt_m    = cur_m.data;
                    endcase
                    K_RD:    exp_tx_m = reg_val(cur_m.addr);
                    default: nxt_m = 8'h00;
                endcase
            end
            cnt_m = nxt_m;
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h (edge %0d)", name, act, exp, n_edge);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check8("count", count, cnt_m);
            check8("led", {4'h0, led}, {4'h0, led_m});
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic wait_neg(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned e);
        while (n_edge < e) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce0   = 1'b1;
        n_edge = 0; ctrl_m = 8'h00; step_m = 8'h01; ledreg_m = 8'h00; cnt_m = 8'h00;
        cnt_prev_m = 8'h00; exp_tx_m = 8'h00; led_m = 4'h0;
        aq.delete();
        #1;
        check8("rst_count", count, 8'h00);
        check8("rst_led", {4'h0, led}, 8'h00);
        check8("rst_tx", tx_byte, 8'h00);
        check8("rst_busy", {7'h0, busy}, 8'h00);
        wait_neg(3);
        rst_n = 1'b1;
    endtask

    task automatic cs_low();
        ce0 = 1'b0;
        wait_neg(4);
        check8("busy_hi", {7'h0, busy}, 8'h01);
    endtask

    task automatic cs_high();
        ce0 = 1'b1;
        wait_neg(5);
        check8("busy_lo", {7'h0, busy}, 8'h00);
        check8("idle_tx", tx_byte, cnt_prev_m);
    endtask

    // Presents one byte; its effect lands 4 edges later (optionally on a tick edge).
    task automatic send_byte(input logic [7:0] b, input bit align, input bit push,
                             input act_t a, output int unsigned at);
        act_t p;
        if (align) while ((n_edge % PRESCALE) != 0) @(negedge clk);
        rx_byte   = b;
        rx_toggle = ~rx_toggle;
        at = n_edge + 4;
        if (push) begin
            p = a;
            p.at = at;
            aq.push_back(p);
        end
    endtask

    task automatic xact(input logic [7:0] cmd, input logic [7:0] data, input int exp_rd);
        act_t a;
        int unsigned at;
        a.at = 0; a.addr = cmd[1:0]; a.data = data; a.kind = K_WR;
        cs_low();
        case (cmd[7:6])
            2'b01: begin
                send_byte(cmd, 1'b0, 1'b0, a, at);
                wait_neg(7);
                send_byte(data, 1'b0, 1'b1, a, at);
            end
            2'b10: begin a.kind = K_RD;  send_byte(cmd, 1'b0, 1'b1, a, at); end
            2'b11: begin a.kind = K_CLR; send_byte(cmd, 1'b0, 1'b1, a, at); end
            default: send_byte(cmd, 1'b0, 1'b0, a, at);
        endcase
        wait_neg(7);
        if (cmd[7:6] == 2'b10) begin
            check8("read_model", tx_byte, exp_tx_m);
            if (exp_rd >= 0) check8("read_const", tx_byte, 8'(exp_rd));
        end
        cs_high();
    endtask

    task automatic write_aligned(input logic [1:0] addr, input logic [7:0] data,
                                 output int unsigned at);
        act_t a;
        int unsigned t0;
        a.at = 0; a.kind = K_WR; a.addr = addr; a.data = data;
        cs_low();
        send_byte({2'b01, 4'b0000, addr}, 1'b0, 1'b0, a, t0);
        wait_neg(7);
        send_byte(data, 1'b1, 1'b1, a, at);
    endtask

    initial begin
        int unsigned at;
        logic [7:0]  c_exp;
        act_t        dummy;
        vt[0] = '{8'h41, 8'h07, 8'h81, 8'h07, 4'hA};
        vt[1] = '{8'h42, 8'h5C, 8'h82, 8'h5C, 4'hC};
        vt[2] = '{8'h43, 8'h33, 8'h83, 8'h33, 4'hC};
        vt[3] = '{8'hC0, 8'h00, 8'h83, 8'h00, 4'hC};
        vt[4] = '{8'h40, 8'h02, 8'h80, 8'h02, 4'hC};
        vt[5] = '{8'h3F, 8'hEE, 8'hBD, 8'h07, 4'hC};
        vt[6] = '{8'h7E, 8'h03, 8'h82, 8'h03, 4'h3};
        dummy.at = 0; dummy.kind = K_WR; dummy.addr = 2'd0; dummy.data = 8'h00;

        #1;
        do_reset();
        wait_neg(100);
        check8("quiet_count", count, 8'h00);
        check8("quiet_led", {4'h0, led}, 8'h00);
        check8("quiet_tx", tx_byte, 8'h00);

        xact(8'h42, 8'h0A, -1);
        check8("led_write", {4'h0, led}, 8'h0A);
        xact(8'h82, 8'h00, 8'h0A);

        for (int i = 0; i < 7; i++) begin
            xact(vt[i].cmd, vt[i].data, -1);
            xact(vt[i].rd_cmd, 8'h00, int'(vt[i].exp_rd));
            check8("vec_led", {4'h0, led}, {4'h0, vt[i].exp_led});
        end

        // Up-count wrap with STEP=3 from 0xFD, then down-count wrap from 0x00.
        xact(8'h41, 8'h03, -1);
        xact(8'h43, 8'hFD, -1);
        write_aligned(2'd0, 8'h01, at);
        wait_until(at);
        check8("wrap_pre", count, 8'hFD);
        wait_until(at + 4);
        check8("wrap_up", count, 8'h00);
        wait_until(at + 8);
        check8("wrap_up2", count, 8'h03);
        cs_high();
        xact(8'h40, 8'h00, -1);
        xact(8'h43, 8'h00, -1);
        write_aligned(2'd0, 8'h03, at);
        wait_until(at);
        check8("down_pre", count, 8'h00);
        wait_until(at + 4);
        check8("wrap_down", count, 8'hFD);
        cs_high();
        xact(8'h40, 8'h00, -1);

        // Host write of COUNT on a tick edge wins; next tick resumes from it.
        xact(8'h41, 8'h01, -1);
        xact(8'h40, 8'h01, -1);
        write_aligned(2'd3, 8'h55, at);
        wait_until(at);
        check8("collide", count, 8'h55);
        wait_until(at + 4);
        check8("collide_next", count, 8'h56);
        cs_high();
        xact(8'h40, 8'h00, -1);

        // WRITE COUNT aborted by ce0 release before the data byte.
        c_exp = cnt_m;
        cs_low();
        send_byte(8'h43, 1'b0, 1'b0, dummy, at);
        wait_neg(7);
        cs_high();
        send_byte(8'h99, 1'b0, 1'b0, dummy, at);
        wait_neg(8);
        check8("abort_count", count, c_exp);
        xact(8'h83, 8'h00, int'(c_exp));

        for (int i = 0; i < 50; i++) begin
            logic [7:0] cmd, d;
            cmd = 8'($urandom);
            d   = 8'($urandom);
            wait_neg(int'($urandom_range(0, 6)));
            xact(cmd, d, -1);
        end

        // Reset while a WRITE waits in DATA, then a stale toggle with ce0 high.
        cs_low();
        send_byte(8'h43, 1'b0, 1'b0, dummy, at);
        wait_neg(5);
        do_reset();
        rx_byte   = 8'h5A;
        rx_toggle = ~rx_toggle;
        wait_neg(10);
        check8("post_rst_busy", {7'h0, busy}, 8'h00);
        check8("post_rst_count", count, 8'h00);
        check8("post_rst_tx", tx_byte, 8'h00);
        xact(8'h43, 8'h12, -1);
        xact(8'h83, 8'h00, 8'h12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
